// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared types and constants for the execute stage
package execute_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SHL, OP_SHR, OP_SAR, OP_MOV, OP_DIV
  } op_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {IDLE, DIVIDE, STORE} state_t;

  localparam int NO_DESTINATION = 0;

endpackage

// File: rtl/execute_divider.sv
// rtl/execute_divider.sv - restoring unsigned divider, one quotient bit per cycle
// done is combinational: it marks the cycle whose edge produces the final quotient.
module execute_divider #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  input  logic             finish_en,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV_CYCLES - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             last_step;

  always_comb begin
    rem_shift   = {rem_q, quo_q[WIDTH-1]};
    trial       = rem_shift - {1'b0, divisor_q};
    fits        = !trial[WIDTH];
    step_rem    = fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    step_quo    = {quo_q[WIDTH-2:0], fits};
    last_step   = busy_q && (count_q == '0);
    div_by_zero = start && (divisor == '0);
    done        = div_by_zero || (last_step && finish_en && !abort);
    quotient    = div_by_zero ? '1 : step_quo;

    busy_d    = busy_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;

    if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      // The last step waits at count 0 until the result can be taken downstream.
      if (!last_step) begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q - 1'b1;
      end else if (finish_en) begin
        rem_d  = step_rem;
        quo_d  = step_quo;
        busy_d = 1'b0;
      end
    end else if (start && !div_by_zero) begin
      busy_d    = 1'b1;
      count_d   = LAST_COUNT;
      rem_d     = '0;
      quo_d     = dividend;
      divisor_d = divisor;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
    end else begin
      busy_q    <= busy_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
    end
  end

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - execute stage: inline ALU, iterative divide, store handshake
// Result bundle is registered; hold_out stalls the read stage while busy or held.
module execute
  import execute_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_BITS   = 4,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_pc,
  input  op_t                 in_operation,
  input  logic [REG_BITS-1:0] in_destination,
  input  logic [WIDTH-1:0]    in_left,
  input  logic [WIDTH-1:0]    in_right,
  input  logic [WIDTH-1:0]    in_adjustment,
  input  logic                in_is_writing_memory,
  input  logic                in_has_flushed,
  output logic                hold_out,
  input  logic                flush,
  output logic                mem_write_enable,
  output logic [WIDTH-1:0]    mem_address,
  output logic [WIDTH-1:0]    mem_data,
  input  logic                mem_ready,
  input  logic                hold_in,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_pc,
  output logic [REG_BITS-1:0] out_destination,
  output logic [WIDTH-1:0]    out_value,
  output logic [3:0]          out_flags,
  output logic                out_has_flushed
);

  localparam int SHIFT_BITS = $clog2(WIDTH);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [REG_BITS-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]    mem_address_q, mem_address_d;
  logic [WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_pc_q, out_pc_d;
  logic [REG_BITS-1:0] out_destination_q, out_destination_d;
  logic [WIDTH-1:0]    out_value_q, out_value_d;
  logic [3:0]          out_flags_q, out_flags_d;
  logic                out_has_flushed_q, out_has_flushed_d;

  logic                accept;
  logic                div_start;
  logic                div_abort;
  logic                div_done;
  logic                div_by_zero;
  logic [WIDTH-1:0]    div_quotient;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [SHIFT_BITS-1:0] shamt;
  logic [WIDTH-1:0]    alu_value;
  logic                alu_c;
  logic                alu_v;

  logic                finish;
  logic [WIDTH-1:0]    fin_value;
  logic [WIDTH-1:0]    fin_pc;
  logic [REG_BITS-1:0] fin_dest;
  logic                fin_c;
  logic                fin_v;

  execute_divider #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clock       (clock),
    .reset       (reset),
    .start       (div_start),
    .dividend    (in_left),
    .divisor     (in_right),
    .abort       (div_abort),
    .finish_en   (!hold_in),
    .done        (div_done),
    .div_by_zero (div_by_zero),
    .quotient    (div_quotient)
  );

  always_comb begin
    shamt     = in_right[SHIFT_BITS-1:0];
    sum       = {1'b0, in_left} + {1'b0, in_right};
    diff      = {1'b0, in_left} - {1'b0, in_right};
    alu_value = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (in_operation)
      OP_ADD: begin
        alu_value = sum[WIDTH-1:0];
        alu_c     = sum[WIDTH];
        alu_v     = (in_left[WIDTH-1] == in_right[WIDTH-1]) && (sum[WIDTH-1] != in_left[WIDTH-1]);
      end
      OP_SUB: begin
        alu_value = diff[WIDTH-1:0];
        alu_c     = !diff[WIDTH];
        alu_v     = (in_left[WIDTH-1] != in_right[WIDTH-1]) && (diff[WIDTH-1] != in_left[WIDTH-1]);
      end
      OP_AND:  alu_value = in_left & in_right;
      OP_OR:   alu_value = in_left | in_right;
      OP_XOR:  alu_value = in_left ^ in_right;
      OP_SHL:  alu_value = in_left << shamt;
      OP_SHR:  alu_value = in_left >> shamt;
      OP_SAR:  alu_value = $signed(in_left) >>> shamt;
      OP_MOV:  alu_value = in_right;
      default: alu_value = '0;
    endcase
  end

  always_comb begin
    accept    = in_valid && (state_q == IDLE) && !hold_in;
    hold_out  = !reset && (hold_in || (state_q != IDLE));
    div_start = accept && !in_is_writing_memory && (in_operation == OP_DIV);
    div_abort = flush && (state_q == DIVIDE);

    state_d           = state_q;
    pc_d              = pc_q;
    dest_d            = dest_q;
    mem_address_d     = mem_address_q;
    mem_data_d        = mem_data_q;
    out_valid_d       = out_valid_q;
    out_pc_d          = out_pc_q;
    out_destination_d = out_destination_q;
    out_value_d       = out_value_q;
    out_flags_d       = out_flags_q;
    out_has_flushed_d = out_has_flushed_q;

    finish    = 1'b0;
    fin_value = alu_value;
    fin_c     = alu_c;
    fin_v     = alu_v;
    fin_pc    = in_pc;
    fin_dest  = in_destination;

    // With writeback stalled the whole result bundle freezes.
    if (!hold_in) begin
      out_valid_d       = 1'b0;
      out_has_flushed_d = in_has_flushed;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_writing_memory) begin
            state_d       = STORE;
            pc_d          = in_pc;
            mem_address_d = in_left + in_adjustment;
            mem_data_d    = in_right;
          end else if (in_operation == OP_DIV) begin
            if (div_done) begin
              finish    = 1'b1;
              fin_value = div_quotient;
              fin_c     = 1'b0;
              fin_v     = div_by_zero;
            end else begin
              state_d = DIVIDE;
              pc_d    = in_pc;
              dest_d  = in_destination;
            end
          end else begin
            finish = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (div_done) begin
          state_d   = IDLE;
          finish    = 1'b1;
          fin_value = div_quotient;
          fin_c     = 1'b0;
          fin_v     = 1'b0;
          fin_pc    = pc_q;
          fin_dest  = dest_q;
        end
      end
      STORE: begin
        if (mem_ready && !hold_in) begin
          state_d           = IDLE;
          out_valid_d       = 1'b1;
          out_pc_d          = pc_q;
          out_destination_d = REG_BITS'(NO_DESTINATION);
          out_value_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      out_valid_d         = 1'b1;
      out_pc_d            = fin_pc;
      out_destination_d   = fin_dest;
      out_value_d         = fin_value;
      out_flags_d[FLAG_Z] = (fin_value == '0);
      out_flags_d[FLAG_N] = fin_value[WIDTH-1];
      out_flags_d[FLAG_C] = fin_c;
      out_flags_d[FLAG_V] = fin_v;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      pc_q              <= '0;
      dest_q            <= '0;
      mem_address_q     <= '0;
      mem_data_q        <= '0;
      out_valid_q       <= 1'b0;
      out_pc_q          <= '0;
      out_destination_q <= '0;
      out_value_q       <= '0;
      out_flags_q       <= '0;
      out_has_flushed_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      dest_q            <= dest_d;
      mem_address_q     <= mem_address_d;
      mem_data_q        <= mem_data_d;
      out_valid_q       <= out_valid_d;
      out_pc_q          <= out_pc_d;
      out_destination_q <= out_destination_d;
      out_value_q       <= out_value_d;
      out_flags_q       <= out_flags_d;
      out_has_flushed_q <= out_has_flushed_d;
    end
  end

  assign mem_write_enable = (state_q == STORE);
  assign mem_address      = mem_address_q;
  assign mem_data         = mem_data_q;
  assign out_valid        = out_valid_q;
  assign out_pc           = out_pc_q;
  assign out_destination  = out_destination_q;
  assign out_value        = out_value_q;
  assign out_flags        = out_flags_q;
  assign out_has_flushed  = out_has_flushed_q;

endmodule
